parity_stream_checker: RTL and testbench
========================================

# parity_stream_checker

Registered stream stage that checks each incoming word against its even-parity code bit and forwards the word downstream tagged with an error flag. It sits directly after a parity-protected storage or transport element, such as a RAM read port, CDC path or bus segment, where the data and its parity code arrive together. It also keeps error statistics for software and safety logic: a saturating error counter, a sticky error flag, and a capture of the first failing word.

## Interface

Parameters:
- DATA_WIDTH, 8, width of the protected data word (≥1)
- COUNT_WIDTH, 8, width of the saturating error counter (≥1)

Ports:
- clock  input  1  single clock; all state updates on the rising edge
- resetn  input  1  asynchronous active-low reset
- input_valid  input  1  upstream word present
- input_ready  output  1  stage can accept a word this cycle
- input_data  input  DATA_WIDTH  protected data
- input_code  input  1  even-parity code bit (XOR of all data bits)
- output_valid  output  1  registered word present
- output_ready  input  1  downstream accepts the word this cycle
- output_data  output  DATA_WIDTH  registered data, passed unmodified
- output_error  output  1  parity mismatch detected on the registered word
- clear  input  1  synchronous clear of the statistics
- error_count  output  COUNT_WIDTH  number of erroneous words accepted, saturating
- error_sticky  output  1  set on the first erroneous word accepted, held until clear
- error_capture_data  output  DATA_WIDTH  data of the first erroneous word since reset or clear
- error_capture_code  output  1  code bit of that word

## Operation

- Parity check:
  - mismatch = input_code XOR (XOR-reduce input_data).
  - A mismatch of 1 means error.
  - The check is evaluated on the input side; the result is registered with the data.
- Handshake:
  - The stage is one register slot, implemented as a valid/ready pipeline register.
  - input_ready = !output_valid || output_ready. This is combinational from output_ready; no other combinational input-to-output paths exist.
  - Accept = input_valid && input_ready.
  - Emit = output_valid && output_ready.
- Register slot update:
  - On accept: output_data ← input_data, output_error ← mismatch, output_valid ← 1.
  - On emit without accept: output_valid ← 0. output_data and output_error hold their values (don't-care while output_valid is 0).
  - Emit and accept in the same cycle: the slot is replaced. Full throughput is one word per cycle.
  - While output_valid && !output_ready, output_data and output_error are stable. Upstream sees input_ready = 0.
- Statistics are updated only on accepted words. A mismatch while input_valid is 0, or while stalled, has no effect.
  - error_count increments by 1 per accepted erroneous word. It saturates at 2^COUNT_WIDTH−1 and never wraps.
  - error_sticky is set on an accepted erroneous word.
  - error_capture_data/code load only when error_sticky is 0 (or is being cleared that cycle). The first error is held.
- clear:
  - Resets error_count, error_sticky, error_capture_data and error_capture_code to 0 on the next edge.
  - Does not affect the register slot or the handshake.
- clear together with an accepted erroneous word: clear is applied first, then the event. Result: error_count = 1, error_sticky = 1, capture = the new word.
- clear together with an accepted clean word: all statistics become 0.

## Timing

- Latency: 1 cycle from accept to output_valid.
- Statistics update on the same edge as the accept, so they become visible together with output_valid of that word.
- Reset values: input_ready = 1 (follows from output_valid = 0). All other outputs are 0.
- Reset mid-operation: asynchronous assertion immediately drops output_valid and zeroes all statistics. Any word in the slot is discarded. Deassertion is assumed synchronised by the reset tree.

## Test plan

- Reset, DATA_WIDTH = 8: all outputs 0, input_ready = 1. Send 0xA5 with code 0 (clean): the next cycle gives output_valid = 1, output_data = 0xA5, output_error = 0, error_count = 0.
- Send 0x01 with code 0 (error), then 0x03 with code 1 (error): output_error = 1 for both. error_count = 2, error_sticky = 1, capture = 0x01/0 (the first error only).
- Hold output_ready = 0 with the slot full: input_ready = 0 and output_data is stable for 5 cycles. An erroneous input_valid word presented meanwhile does not change error_count. Release output_ready: the stalled word is emitted and the pending word is accepted the same cycle.
- COUNT_WIDTH = 2, send 5 erroneous words back-to-back with output_ready = 1: error_count reads 1, 2, 3, 3, 3. Throughput is one word per cycle.
- Assert clear in the same cycle as accepting erroneous 0x7F/0: error_count = 1, error_sticky = 1, capture = 0x7F/0. A clear with no error gives all statistics 0, and the slot contents are untouched.
- Assert resetn low mid-stream with the slot full and error_count = 3: output_valid, error_count, error_sticky and the capture outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/parity_stream_checker.sv
// Registered valid/ready stage that checks even parity on each word and
// keeps error statistics (saturating count, sticky flag, first-error capture).
module parity_stream_checker #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [DATA_WIDTH-1:0]  input_data,
    input  logic                   input_code,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [DATA_WIDTH-1:0]  output_data,
    output logic                   output_error,
    input  logic                   clear,
    output logic [COUNT_WIDTH-1:0] error_count,
    output logic                   error_sticky,
    output logic [DATA_WIDTH-1:0]  error_capture_data,
    output logic                   error_capture_code
);

    localparam logic [COUNT_WIDTH-1:0] CountMax = {COUNT_WIDTH{1'b1}};

    logic                   valid_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   err_q;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   sticky_q, sticky_d;
    logic [DATA_WIDTH-1:0]  cap_data_q, cap_data_d;
    logic                   cap_code_q, cap_code_d;

    logic mismatch;
    logic accept;
    logic emit;

    assign mismatch    = input_code ^ (^input_data);
    assign input_ready = !valid_q || output_ready;
    assign accept      = input_valid && input_ready;
    assign emit        = valid_q && output_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= input_data;
            err_q   <= mismatch;
        end else if (emit) begin
            valid_q <= 1'b0;
        end
    end

    // Clear takes effect first, so an error in the same cycle starts fresh.
    always_comb begin
        count_d    = clear ? '0 : count_q;
        sticky_d   = clear ? 1'b0 : sticky_q;
        cap_data_d = clear ? '0 : cap_data_q;
        cap_code_d = clear ? 1'b0 : cap_code_q;
        if (accept && mismatch) begin
            if (count_d != CountMax) begin
                count_d = count_d + 1'b1;
            end
            if (!sticky_d) begin
                cap_data_d = input_data;
                cap_code_d = input_code;
            end
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q    <= '0;
            sticky_q   <= 1'b0;
            cap_data_q <= '0;
            cap_code_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            sticky_q   <= sticky_d;
            cap_data_q <= cap_data_d;
            cap_code_q <= cap_code_d;
        end
    end

    assign output_valid       = valid_q;
    assign output_data        = data_q;
    assign output_error       = err_q;
    assign error_count        = count_q;
    assign error_sticky       = sticky_q;
    assign error_capture_data = cap_data_q;
    assign error_capture_code = cap_code_q;

endmodule

// File: tb/tb_parity_stream_checker.sv
// Scoreboard bench for parity_stream_checker: driver pushes expected words,
// a monitor pops them on emit; statistics follow a behavioural model.
module tb_parity_stream_checker;

    localparam int DW = 8;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          resetn;
    logic          input_valid;
    logic          input_ready;
    logic [DW-1:0] input_data;
    logic          input_code;
    logic          output_valid;
    logic          output_ready;
    logic [DW-1:0] output_data;
    logic          output_error;
    logic          clear;
    logic [CW-1:0] error_count;
    logic          error_sticky;
    logic [DW-1:0] error_capture_data;
    logic          error_capture_code;

    always #5 clock = ~clock;

    parity_stream_checker #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clock(clock),
        .resetn(resetn),
        .input_valid(input_valid),
        .input_ready(input_ready),
        .input_data(input_data),
        .input_code(input_code),
        .output_valid(output_valid),
        .output_ready(output_ready),
        .output_data(output_data),
        .output_error(output_error),
        .clear(clear),
        .error_count(error_count),
        .error_sticky(error_sticky),
        .error_capture_data(error_capture_data),
        .error_capture_code(error_capture_code)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int passed = 0;

    bit            m_valid;
    int            m_cnt;
    bit            m_sticky;
    logic [DW-1:0] m_cd;
    logic          m_cc;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_valid  = 0;
        m_cnt    = 0;
        m_sticky = 0;
        m_cd     = '0;
        m_cc     = 1'b0;
    endtask

    // One clock of stimulus: check state left by the previous edge, drive,
    // then advance the model by what the next edge should do.
    task automatic cycle(input bit iv, input logic [DW-1:0] d, input logic c,
                         input bit ordy, input bit clr);
        bit rdy, acc, emt, bad;
        @(negedge clock);
        chk("out_valid", output_valid, m_valid);
        chk("err_count", error_count, m_cnt);
        chk("err_sticky", error_sticky, m_sticky);
        chk("cap_data", error_capture_data, m_cd);
        chk("cap_code", error_capture_code, m_cc);
        input_valid  = iv;
        input_data   = d;
        input_code   = c;
        output_ready = ordy;
        clear        = clr;
        #1;
        rdy = !m_valid || ordy;
        chk("in_ready", input_ready, rdy);
        acc = iv && rdy;
        emt = m_valid && ordy;
        bad = (($countones(d) % 2) == 1) != (c == 1'b1);
        if (acc) q.push_back('{d: d, e: bad});
        if (acc) m_valid = 1;
        else if (emt) m_valid = 0;
        if (clr) begin
            m_cnt = 0; m_sticky = 0; m_cd = '0; m_cc = 1'b0;
        end
        if (acc && bad) begin
            if (m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (!m_sticky) begin
                m_cd = d; m_cc = c;
            end
            m_sticky = 1;
        end
    endtask

    task automatic idle();
        cycle(0, '0, 1'b0, 1, 0);
    endtask

    // Monitor: compare the slot against the queue head, pop on emit.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (resetn && output_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL out_word: valid with data %0h, expected nothing", output_data);
                end else begin
                    chk("out_data", output_data, q[0].d);
                    chk("out_error", output_error, q[0].e);
                    if (output_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        resetn       = 1'b0;
        input_valid  = 1'b0;
        input_data   = '0;
        input_code   = 1'b0;
        output_ready = 1'b0;
        clear        = 1'b0;
        model_reset();
        #12;
        chk("rst_in_ready", input_ready, 1);
        chk("rst_out_valid", output_valid, 0);
        chk("rst_out_data", output_data, 0);
        chk("rst_out_error", output_error, 0);
        chk("rst_count", error_count, 0);
        chk("rst_sticky", error_sticky, 0);
        chk("rst_cap", {error_capture_data, error_capture_code}, 0);
        resetn = 1'b1;

        // clean word, then two errors
        cycle(1, 8'hA5, 1'b0, 1, 0);
        idle();
        cycle(1, 8'h01, 1'b0, 1, 0);
        cycle(1, 8'h03, 1'b1, 1, 0);
        idle();
        chk("two_err_count", error_count, 2);
        chk("two_err_cap_data", error_capture_data, 8'h01);
        chk("two_err_cap_code", error_capture_code, 0);

        // stall: slot full, erroneous word waits, count unchanged
        cycle(1, 8'h5A, 1'b0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 8'h11, 1'b1, 0, 0);
            chk("stall_in_ready", input_ready, 0);
            chk("stall_data", output_data, 8'h5A);
        end
        chk("stall_count", error_count, 2);
        cycle(1, 8'h11, 1'b1, 1, 0);
        idle();
        chk("after_stall_count", error_count, 3);

        // saturation from zero: 1,2,3,3,3
        cycle(0, '0, 1'b0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            if (i < 5) cycle(1, 8'(i + 1), 1'b0 ^ ~(^8'(i + 1)), 1, 0);
            else idle();
            if (i > 0) chk("sat_count", error_count, (i < CMAX) ? i : CMAX);
        end

        // clear together with an error
        cycle(1, 8'h7F, 1'b0, 1, 1);
        idle();
        chk("clr_err_count", error_count, 1);
        chk("clr_err_sticky", error_sticky, 1);
        chk("clr_err_cap", {error_capture_data, error_capture_code}, {8'h7F, 1'b0});

        // clear with a clean word held in the slot
        cycle(1, 8'h3C, 1'b0, 0, 0);
        cycle(0, '0, 1'b0, 0, 1);
        cycle(0, '0, 1'b0, 0, 0);
        chk("clr_slot_valid", output_valid, 1);
        chk("clr_slot_data", output_data, 8'h3C);
        chk("clr_stats", {error_count, error_sticky, error_capture_data}, 0);
        idle();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 1), 8'($urandom), 1'($urandom),
                  ($urandom % 4) != 0, ($urandom % 16) == 0);
        end

        // asynchronous reset with slot full and count saturated
        cycle(0, '0, 1'b0, 1, 1);
        for (int i = 0; i < 4; i++) cycle(1, 8'h80, 1'b0, 1, 0);
        cycle(0, '0, 1'b0, 0, 0);
        chk("pre_rst_valid", output_valid, 1);
        chk("pre_rst_count", error_count, 3);
        resetn = 1'b0;
        #1;
        chk("async_valid", output_valid, 0);
        chk("async_count", error_count, 0);
        chk("async_sticky", error_sticky, 0);
        chk("async_cap", {error_capture_data, error_capture_code}, 0);
        chk("async_ready", input_ready, 1);
        model_reset();
        input_valid = 1'b0;
        @(negedge clock);
        #3;
        resetn = 1'b1;

        for (int i = 0; i < 100; i++) begin
            cycle($urandom_range(0, 1), 8'($urandom), 1'($urandom),
                  ($urandom % 3) != 0, ($urandom % 20) == 0);
        end
        idle();
        idle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
